// File: rtl/conv_pkg.sv
// Shared definitions for the convolution controller and the window fetch unit:
// tap count, fetch FSM state encodings and the 3x3 neighbourhood offsets.
package conv_pkg;

   localparam int NUM_TAPS         = 9;
   localparam int DEFAULT_IMG_LOG2 = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fetchState_e;

   // Row and column offsets of tap k relative to the centre pixel:
   // dr = k/3 - 1, dc = k%3 - 1, so tap 4 is the centre itself.
   localparam logic signed [1:0] TAP_DR [NUM_TAPS] = '{
      -2'sd1, -2'sd1, -2'sd1,
       2'sd0,  2'sd0,  2'sd0,
       2'sd1,  2'sd1,  2'sd1
   };
   localparam logic signed [1:0] TAP_DC [NUM_TAPS] = '{
      -2'sd1,  2'sd0,  2'sd1,
      -2'sd1,  2'sd0,  2'sd1,
      -2'sd1,  2'sd0,  2'sd1
   };

endpackage

// File: rtl/tap_return_pipe.sv
// Tracks outstanding RAM reads: a fixed-depth shift register of {valid, tag}
// whose output lines up with the cycle the RAM returns the matching data.
module tap_return_pipe #(
   parameter int RD_LAT = 1,
   parameter int TAG_W  = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   output logic [TAG_W-1:0] o_tag
);

   logic [TAG_W:0] stage_q [RD_LAT];

   // Shift one entry per cycle; reset flushes every stage so late data is dropped.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < RD_LAT; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= {i_valid, i_tag};
         for (int i = 1; i < RD_LAT; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign {o_valid, o_tag} = stage_q[RD_LAT-1];

endmodule

// File: rtl/window_fetch_unit.sv
// Fetches a 3x3 window from the feature-map RAM, one tap per cycle, replacing
// taps that fall outside the image with zero. ADDR_W must equal 2*IMG_LOG2.
module window_fetch_unit
   import conv_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int IMG_LOG2 = DEFAULT_IMG_LOG2,
   parameter int ADDR_W   = 12,
   parameter int RD_LAT   = 1
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_start,
   input  logic [NUM_TAPS*ADDR_W-1:0]   i_addrRead,
   input  logic [ADDR_W-1:0]            i_centerAddr,
   output logic [ADDR_W-1:0]            o_ramAddr,
   output logic                         o_ramRe,
   input  logic [DATA_W-1:0]            i_ramData,
   output logic [NUM_TAPS*DATA_W-1:0]   o_window,
   output logic [NUM_TAPS-1:0]          o_padMask,
   output logic                         o_valid,
   output logic                         o_busy
);

   localparam logic [3:0] LAST_TAP = 4'(NUM_TAPS - 1);

   fetchState_e                 state_q;
   logic [3:0]                  tapCnt_q;
   logic [2:0]                  drainCnt_q;
   logic [NUM_TAPS*ADDR_W-1:0]  addrRead_q;
   logic [ADDR_W-1:0]           centerAddr_q;
   logic [ADDR_W-1:0]           ramAddr_q;
   logic                        ramRe_q;
   logic [NUM_TAPS*DATA_W-1:0]  window_q;
   logic [NUM_TAPS-1:0]         padMask_q;
   logic                        valid_q;
   logic                        busy_q;

   logic [3:0]                  nextTap_d;
   logic [ADDR_W-1:0]           lookCenter;
   logic [NUM_TAPS*ADDR_W-1:0]  lookAddrs;
   logic                        nextOob_d;
   logic [ADDR_W-1:0]           nextAddr_d;

   logic                        retValid;
   logic [3:0]                  retTag;

   // The image bounds check works on row/col widened by one bit, so a step
   // past either edge shows up in the top bit instead of wrapping around.
   function automatic logic tapOutOfBounds(input logic [ADDR_W-1:0] center,
                                           input logic [3:0]        k);
      logic [IMG_LOG2:0] rowExt;
      logic [IMG_LOG2:0] colExt;
      rowExt = {1'b0, center[2*IMG_LOG2-1:IMG_LOG2]}
             + {{(IMG_LOG2-1){TAP_DR[k][1]}}, TAP_DR[k]};
      colExt = {1'b0, center[IMG_LOG2-1:0]}
             + {{(IMG_LOG2-1){TAP_DC[k][1]}}, TAP_DC[k]};
      return rowExt[IMG_LOG2] | colExt[IMG_LOG2];
   endfunction

   // Look one tap ahead so the RAM strobe and address come straight from flops:
   // in IDLE that is tap 0 of the incoming request, in ISSUE the following tap.
   always_comb begin
      nextTap_d  = 4'd0;
      lookCenter = centerAddr_q;
      lookAddrs  = addrRead_q;
      if (state_q == ST_IDLE) begin
         lookCenter = i_centerAddr;
         lookAddrs  = i_addrRead;
      end else if (tapCnt_q != LAST_TAP) begin
         nextTap_d = tapCnt_q + 4'd1;
      end else begin
         nextTap_d = LAST_TAP;
      end
      nextOob_d  = tapOutOfBounds(lookCenter, nextTap_d);
      nextAddr_d = lookAddrs[nextTap_d*ADDR_W +: ADDR_W];
   end

   // Main fetch FSM: issue nine taps, wait out the RAM latency, pulse valid.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         tapCnt_q     <= '0;
         drainCnt_q   <= '0;
         addrRead_q   <= '0;
         centerAddr_q <= '0;
         ramAddr_q    <= '0;
         ramRe_q      <= 1'b0;
         window_q     <= '0;
         padMask_q    <= '0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         ramRe_q   <= 1'b0;
         ramAddr_q <= '0;
         if (retValid) begin
            window_q[retTag*DATA_W +: DATA_W] <= i_ramData;
         end
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  addrRead_q   <= i_addrRead;
                  centerAddr_q <= i_centerAddr;
                  window_q     <= '0;
                  padMask_q    <= '0;
                  busy_q       <= 1'b1;
                  tapCnt_q     <= '0;
                  ramRe_q      <= !nextOob_d;
                  ramAddr_q    <= nextOob_d ? '0 : nextAddr_d;
                  state_q      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               padMask_q[tapCnt_q] <= !ramRe_q;
               if (tapCnt_q == LAST_TAP) begin
                  drainCnt_q <= '0;
                  state_q    <= ST_DRAIN;
               end else begin
                  tapCnt_q  <= nextTap_d;
                  ramRe_q   <= !nextOob_d;
                  ramAddr_q <= nextOob_d ? '0 : nextAddr_d;
               end
            end
            ST_DRAIN: begin
               if (drainCnt_q == 3'(RD_LAT - 1)) begin
                  valid_q <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  drainCnt_q <= drainCnt_q + 3'd1;
               end
            end
            ST_DONE: begin
               busy_q   <= 1'b0;
               tapCnt_q <= '0;
               state_q  <= ST_IDLE;
            end
            default: begin
               busy_q   <= 1'b0;
               tapCnt_q <= '0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

   tap_return_pipe #(
      .RD_LAT (RD_LAT),
      .TAG_W  (4)
   ) u_returnPipe (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_valid (ramRe_q),
      .i_tag   (tapCnt_q),
      .o_valid (retValid),
      .o_tag   (retTag)
   );

   assign o_ramAddr = ramAddr_q;
   assign o_ramRe   = ramRe_q;
   assign o_window  = window_q;
   assign o_padMask = padMask_q;
   assign o_valid   = valid_q;
   assign o_busy    = busy_q;

endmodule
